joy_db15_serial: RTL and testbench
==================================

// Module: joy_db15_serial
// PURPOSE
//  Reads two DB15 arcade sticks through the UserIO serial adapter (parallel-load shift register chain)
//  and presents two 16-bit active-high joystick words to the emu joystick mux (joydb_1/joydb_2 path).
//  Generates JOY_CLK/JOY_LOAD, samples JOY_DATA, optionally filters glitches across frames, and
//  blanks outputs when no adapter is detected. Sits directly upstream of the USB/DB joystick select.
// PARAMETERS
//  CLK_DIV    250  clk cycles per tick (50 MHz -> 5 us tick); legal >= 2
//  GAP_TICKS  134  idle ticks between frames (default frame = 2+64+134 = 200 ticks = 1 ms)
//  FILTER     1    1 = outputs update only when two consecutive frames match; 0 = every frame
// PORTS
//  clk          in   1   system clock (40-50 MHz)
//  reset        in   1   synchronous, active-high reset
//  JOY_DATA     in   1   serial data from adapter, active low (0 = pressed)
//  JOY_CLK      out  1   shift clock to adapter
//  JOY_LOAD     out  1   parallel-load strobe to adapter, active low
//  joystick1    out  16  player 1 buttons, active high (LS FEDCBA UDLR, bit0 = R)
//  joystick2    out  16  player 2 buttons, same layout
//  frame_valid  out  1   1-cycle pulse on the cycle joystick1/2 are written
//  present      out  1   1 = adapter detected on last captured frame
// BEHAVIOUR
//  - tick: 1-cycle internal pulse every CLK_DIV clk; divider counts 0..CLK_DIV-1, restarts at 0 on reset.
//  - FSM (advances on tick only): LOAD -> SHIFT_LO -> SHIFT_HI -> ... -> GAP -> LOAD.
//    LOAD: JOY_LOAD=0, JOY_CLK=0 for 2 ticks; bit index k=0.
//    SHIFT_LO: JOY_LOAD=1, JOY_CLK=0; on the tick leaving this state sample ~JOY_DATA into bit k.
//    SHIFT_HI: JOY_CLK=1 for 1 tick; then k=k+1; k==31 leaving SHIFT_HI -> GAP, else -> SHIFT_LO.
//    GAP: JOY_CLK=0, JOY_LOAD=1 for GAP_TICKS ticks; on the tick entering GAP the frame is captured.
//  - 32 bits per frame, 2 ticks per bit; stream bit k<16 -> joystick1[k], k>=16 -> joystick2[k-16].
//  - JOY_CLK/JOY_LOAD are registered outputs; no combinational path from JOY_DATA to any output.
//  - Presence: captured frame of all-ones after inversion (JOY_DATA stuck low, all 32 bits pressed)
//    = adapter absent -> present=0, joystick1/2 forced to 0, frame_valid pulses. Any other frame -> present=1.
//  - Filter (FILTER=1): captured frame compared to previous captured frame (prev holds 0 after reset);
//    equal -> write outputs + frame_valid; differ -> outputs hold, no pulse, prev <= new. Absent frames bypass
//    filter (clear outputs immediately) and set prev to all-ones.
//  - FILTER=0: every present frame written, frame_valid every frame.
//  - Latency: outputs written 1 clk after the capture tick; frame_valid coincides with new output value.
//  - Reset (any time, incl. mid-frame): JOY_CLK=0, JOY_LOAD=1, joystick1/2=0, frame_valid=0, present=0,
//    prev=0, k=0, FSM=LOAD on first tick after release; partial frame discarded, no update.
//  - Simultaneous: a sample tick and divider wrap are the same event; capture and filter compare occur
//    on one edge; reset has priority over all.
// TESTING (sim with CLK_DIV=4, GAP_TICKS=2)
//  1 reset held 10 clk then released -> JOY_LOAD=0 after first tick for 8 clk, then 32 JOY_CLK pulses,
//    each high 4 clk; frame period 68 ticks = 272 clk; outputs 0 throughout reset.
//  2 model drives P1 R+Fire (stream bits 0,4 low), FILTER=1 -> no update after frame 1;
//    after frame 2 joystick1=16'h0011, joystick2=0, present=1, one frame_valid pulse.
//  3 single-frame glitch: frame N bit 20 low only -> joystick2 unchanged (0), no frame_valid on N or N+1.
//  4 JOY_DATA tied 0 -> after first frame present=0, joystick1/2=0 with frame_valid; releasing to
//    idle-high stream -> present=1 after the next frame, outputs 0 after the second.
//  5 assert reset at bit k=10 of a frame -> JOY_CLK=0/JOY_LOAD=1 next clk, outputs cleared, next frame
//    starts with LOAD, no stale frame_valid.
//  6 FILTER=0, alternate P2 Start (bit 16+10) each frame -> joystick2[10] toggles every frame, frame_valid each.

Source files
------------

// File: rtl/joy_db15_serial.sv
// DB15 arcade stick reader for the UserIO serial adapter: drives the parallel-load
// shift register chain, shifts in 32 bits per frame and publishes two 16-bit stick words.
module joy_db15_serial #(
  parameter int CLK_DIV   = 250,
  parameter int GAP_TICKS = 134,
  parameter int FILTER    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_valid,
  output logic        present
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(GAP_TICKS + 3);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LO, S_HI, S_GAP
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div;
  logic            tick;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [4:0]      k, k_n;
  logic            sample, capture;
  logic [31:0]     sh, prev;

  assign tick = (div == DW'(CLK_DIV - 1));

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    k_n     = k;
    sample  = 1'b0;
    capture = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          state_n = S_LOAD;
          tcnt_n  = '0;
        end
        S_LOAD: begin
          if (tcnt == TW'(1)) begin
            state_n = S_LO;
            tcnt_n  = '0;
            k_n     = '0;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        S_LO: begin
          sample  = 1'b1;
          state_n = S_HI;
        end
        S_HI: begin
          if (k == 5'd31) begin
            state_n = S_GAP;
            capture = 1'b1;
            tcnt_n  = '0;
          end else begin
            k_n     = k + 5'd1;
            state_n = S_LO;
          end
        end
        S_GAP: begin
          if (tcnt == TW'(GAP_TICKS - 1)) begin
            state_n = S_LOAD;
            tcnt_n  = '0;
          end else begin
            tcnt_n = tcnt + TW'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      div         <= '0;
      tcnt        <= '0;
      k           <= '0;
      sh          <= '0;
      prev        <= '0;
      JOY_CLK     <= 1'b0;
      JOY_LOAD    <= 1'b1;
      joystick1   <= '0;
      joystick2   <= '0;
      frame_valid <= 1'b0;
      present     <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DW'(1);
      state       <= state_n;
      tcnt        <= tcnt_n;
      k           <= k_n;
      // Pin drives follow the next state so they change on the same edge as the FSM.
      JOY_CLK     <= (state_n == S_HI);
      JOY_LOAD    <= (state_n != S_LOAD);
      frame_valid <= 1'b0;
      if (sample)
        sh[k] <= ~JOY_DATA;
      if (capture) begin
        if (&sh) begin
          // Data stuck low reads as every button pressed: no adapter plugged in.
          present     <= 1'b0;
          joystick1   <= '0;
          joystick2   <= '0;
          frame_valid <= 1'b1;
          prev        <= '1;
        end else begin
          present <= 1'b1;
          prev    <= sh;
          if (FILTER == 0 || sh == prev) begin
            joystick1   <= sh[15:0];
            joystick2   <= sh[31:16];
            frame_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_serial.sv
// Directed bench for joy_db15_serial: behavioural adapter model, filtered and
// unfiltered instances, and a per-instance scoreboard of expected frame updates.
module tb_joy_db15_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        JOY_DATA;
  logic        jclk1, jload1, fv1, pr1;
  logic        jclk0, jload0, fv0, pr0;
  logic [15:0] j1_1, j2_1, j1_0, j2_0;

  always #5 clk = ~clk;

  joy_db15_serial #(.CLK_DIV(4), .GAP_TICKS(2), .FILTER(1)) u_dut (
    .clk(clk), .reset(reset), .JOY_DATA(JOY_DATA), .JOY_CLK(jclk1), .JOY_LOAD(jload1),
    .joystick1(j1_1), .joystick2(j2_1), .frame_valid(fv1), .present(pr1));

  joy_db15_serial #(.CLK_DIV(4), .GAP_TICKS(2), .FILTER(0)) u_f0 (
    .clk(clk), .reset(reset), .JOY_DATA(JOY_DATA), .JOY_CLK(jclk0), .JOY_LOAD(jload0),
    .joystick1(j1_0), .joystick2(j2_0), .frame_valid(fv0), .present(pr0));

  // Adapter model: parallel load of active-low buttons, shift towards bit 0 on JOY_CLK rise.
  logic [31:0] pat = '0;
  logic [31:0] sr = '1;
  logic        tie0 = 1'b0;
  logic        jclk_d = 1'b0;

  always @(posedge clk) begin
    jclk_d <= jclk1;
    if (jload1 === 1'b0)
      sr <= ~pat;
    else if (jclk1 === 1'b1 && !jclk_d)
      sr <= {1'b1, sr[31:1]};
  end

  assign JOY_DATA = tie0 ? 1'b0 : sr[0];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic        pr;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  always @(negedge clk) begin
    if (!reset && fv1 === 1'b1) begin
      chk("f1_fv_expected", (q1.size() > 0), 1);
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("f1_joystick1", j1_1, e.j1);
        chk("f1_joystick2", j2_1, e.j2);
        chk("f1_present", pr1, e.pr);
      end
    end
    if (!reset && fv0 === 1'b1) begin
      chk("f0_fv_expected", (q0.size() > 0), 1);
      if (q0.size() > 0) begin
        exp_t e;
        e = q0.pop_front();
        chk("f0_joystick1", j1_0, e.j1);
        chk("f0_joystick2", j2_0, e.j2);
        chk("f0_present", pr0, e.pr);
      end
    end
  end

  // Pin timing monitor, sampled on the falling edge.
  int cyc = 0, load_fall = -1, load_len = 0, period = 0;
  int hi_rise = 0, hi_min = 1000, hi_max = 0, pulses = 0, pulses_last = 0;
  logic pl = 1'b1, pc = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (pl === 1'b1 && jload1 === 1'b0) begin
      if (load_fall >= 0) period = cyc - load_fall;
      load_fall   = cyc;
      pulses_last = pulses;
      pulses      = 0;
    end
    if (pl === 1'b0 && jload1 === 1'b1) load_len = cyc - load_fall;
    if (pc === 1'b0 && jclk1 === 1'b1) begin
      hi_rise = cyc;
      pulses++;
    end
    if (pc === 1'b1 && jclk1 === 1'b0) begin
      if (cyc - hi_rise < hi_min) hi_min = cyc - hi_rise;
      if (cyc - hi_rise > hi_max) hi_max = cyc - hi_rise;
    end
    pl = jload1;
    pc = jclk1;
  end

  logic [31:0] m_prev = '0;
  logic        m_pres = 1'b0;

  task automatic wait_load(input logic lvl);
    int g = 0;
    while (jload1 !== lvl && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk(lvl ? "load_rise_timeout" : "load_fall_timeout", (g < 2000), 1);
  endtask

  task automatic wait_pulses(input int cnt);
    int n = 0, g = 0;
    logic p;
    p = jclk1;
    while (n < cnt && g < 2000) begin
      @(negedge clk);
      g++;
      if (jclk1 === 1'b1 && p !== 1'b1) n++;
      p = jclk1;
    end
    chk("jclk_pulse_timeout", n, cnt);
  endtask

  // One full frame carrying active-high button set p; expectations follow the filter rules.
  task automatic do_frame(input logic [31:0] p);
    exp_t e;
    pat  = p;
    tie0 = (p == 32'hFFFF_FFFF);
    wait_load(1'b0);
    wait_load(1'b1);
    if (&p) begin
      e.j1 = '0; e.j2 = '0; e.pr = 1'b0;
      q1.push_back(e);
      q0.push_back(e);
      m_prev = '1;
      m_pres = 1'b0;
    end else begin
      e.j1 = p[15:0]; e.j2 = p[31:16]; e.pr = 1'b1;
      q0.push_back(e);
      if (p == m_prev) q1.push_back(e);
      m_prev = p;
      m_pres = 1'b1;
    end
    wait_pulses(32);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("f1_update_seen", q1.size(), 0);
    chk("f0_update_seen", q0.size(), 0);
    chk("f1_present_level", pr1, m_pres);
    chk("f0_present_level", pr0, m_pres);
  endtask

  initial begin
    int n;
    // Reset state
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_joy_load", jload1, 1);
    chk("rst_joy_clk", jclk1, 0);
    chk("rst_joystick1", j1_1, 0);
    chk("rst_joystick2", j2_1, 0);
    chk("rst_present", pr1, 0);
    chk("rst_frame_valid", fv1, 0);
    reset = 1'b0;
    n = 0;
    while (jload1 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_load_delay", n, 4);

    // P1 R+Fire needs two matching frames
    do_frame(32'h0000_0011);
    chk("frame1_no_update_j1", j1_1, 0);
    do_frame(32'h0000_0011);
    chk("frame2_j1", j1_1, 32'h11);
    chk("load_low_clks", load_len, 8);
    chk("jclk_high_min", hi_min, 4);
    chk("jclk_high_max", hi_max, 4);
    chk("jclk_pulses", pulses_last, 32);
    chk("frame_period", period, 272);

    // Single-frame glitch on stream bit 20
    do_frame(32'h0010_0011);
    chk("glitch_j2_hold", j2_1, 0);
    do_frame(32'h0000_0011);
    chk("glitch_after_j2", j2_1, 0);
    do_frame(32'h0000_0011);
    chk("glitch_settled_j1", j1_1, 32'h11);

    // Reset in the middle of a frame at bit 10
    pat = 32'h0000_0011;
    wait_load(1'b0);
    wait_load(1'b1);
    wait_pulses(10);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_joy_clk", jclk1, 0);
    chk("midrst_joy_load", jload1, 1);
    chk("midrst_joystick1", j1_1, 0);
    chk("midrst_present", pr1, 0);
    chk("midrst_frame_valid", fv1, 0);
    chk("midrst_f0_joystick1", j1_0, 0);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    m_prev = '0;
    m_pres = 1'b0;
    do_frame(32'h0000_0011);
    chk("postrst_j1_hold", j1_1, 0);
    do_frame(32'h0000_0011);
    chk("postrst_j1", j1_1, 32'h11);

    // Adapter absent, then idle-high stream
    do_frame(32'hFFFF_FFFF);
    chk("absent_j1", j1_1, 0);
    do_frame(32'h0000_0000);
    do_frame(32'h0000_0000);

    // Unfiltered instance follows P2 Start toggling every frame
    do_frame(32'h0400_0000);
    chk("f0_start_on", j2_0[10], 1);
    do_frame(32'h0000_0000);
    chk("f0_start_off", j2_0[10], 0);
    do_frame(32'h0400_0000);
    chk("f0_start_on2", j2_0[10], 1);
    chk("f1_start_filtered", j2_1[10], 0);
    chk("pins_match_between_instances", jload0, jload1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
